mxn_scan: RTL and testbench

- Parametrised N-channel, WIDTH-bit multiplexer with a registered output stage and valid/ready handshakes on every input channel and on the output.
- Two modes:
  - Manual: the external select picks the channel.
  - Scan: a round-robin pointer picks the next valid channel.
- Sits between several producers and one consumer. It replaces fixed 2:1 combinational muxing wherever back-pressure or fair sharing is needed.

---
 rtl/mxn_scan_if.sv | 27 ++
 rtl/mxn_scan.sv | 71 +++++++
 tb/tb_mxn_scan.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mxn_scan_if.sv
// Bundle of the mxn_scan producer/consumer signals.
// The master side drives channel data, select and consumer ready; the slave side is the mux.
interface mxn_scan_if #(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int SELW  = 2
);
    logic                  mode;
    logic [SELW-1:0]       sel;
    logic [CH*WIDTH-1:0]   d;
    logic [CH-1:0]         in_valid;
    logic [CH-1:0]         in_ready;
    logic [WIDTH-1:0]      y;
    logic                  y_valid;
    logic [SELW-1:0]       y_ch;
    logic                  out_ready;

    modport master (
        output mode, sel, d, in_valid, out_ready,
        input  in_ready, y, y_valid, y_ch
    );

    modport slave (
        input  mode, sel, d, in_valid, out_ready,
        output in_ready, y, y_valid, y_ch
    );
endinterface

// File: rtl/mxn_scan.sv
// N-channel registered mux with valid/ready handshakes.
// The channel is picked by an external select (manual) or by a round-robin pointer (scan).
module mxn_scan #(
    parameter int WIDTH = 8,
    parameter int CH    = 4,
    parameter int SELW  = 2
) (
    input  logic       clk,
    input  logic       reset,
    mxn_scan_if.slave  bus
);
    localparam logic [SELW:0]   CH_W   = (SELW+1)'(CH);
    localparam logic [SELW-1:0] LAST_CH = SELW'(CH - 1);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  g;
    logic             grant_valid;
    logic             ld;
    logic [SELW:0]    idx;

    // The output register can take a new word when it is empty or being drained.
    assign ld = ~bus.y_valid | bus.out_ready;

    always_comb begin
        grant_valid = 1'b0;
        g           = '0;
        idx         = '0;
        if (!bus.mode) begin
            if ({1'b0, bus.sel} < CH_W) begin
                g           = bus.sel;
                grant_valid = bus.in_valid[bus.sel];
            end
        end else begin
            // Walk downwards so the index closest to ptr is the one left standing.
            for (int k = CH - 1; k >= 0; k--) begin
                idx = {1'b0, ptr} + (SELW+1)'(k);
                if (idx >= CH_W)
                    idx = idx - CH_W;
                if (bus.in_valid[idx[SELW-1:0]]) begin
                    g           = idx[SELW-1:0];
                    grant_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < CH; i++)
            bus.in_ready[i] = ~reset & ld & grant_valid & (g == SELW'(i));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.y       <= '0;
            bus.y_valid <= 1'b0;
            bus.y_ch    <= '0;
            ptr         <= '0;
        end else if (ld) begin
            if (grant_valid) begin
                bus.y       <= bus.d[g*WIDTH +: WIDTH];
                bus.y_ch    <= g;
                bus.y_valid <= 1'b1;
                if (bus.mode)
                    ptr <= (g == LAST_CH) ? '0 : g + SELW'(1);
            end else begin
                bus.y_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mxn_scan.sv
// Directed and random stimulus for mxn_scan, checked against a transaction-level model.
module tb_mxn_scan;
    localparam int WIDTH = 8;
    localparam int CH    = 4;
    localparam int SELW  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mxn_scan_if #(.WIDTH(WIDTH), .CH(CH), .SELW(SELW)) bus ();

    mxn_scan #(.WIDTH(WIDTH), .CH(CH), .SELW(SELW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int compared   = 0;
    int mismatched = 0;

    // Model state: the word held at the output and the scan pointer.
    int m_y     = 0;
    int m_ch    = 0;
    int m_ptr   = 0;
    bit m_valid = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check in_ready before the edge, advance model, check outputs after it.
    task automatic cyc();
        int  g;
        bit  gv;
        bit  ld;
        int  s;
        logic [31:0] exp_ready;
        @(negedge clk);
        g  = 0;
        gv = 0;
        if (!bus.mode) begin
            s = int'(bus.sel);
            if (s < CH && bus.in_valid[s]) begin
                g  = s;
                gv = 1;
            end
        end else begin
            for (int k = 0; k < CH && !gv; k++) begin
                if (bus.in_valid[(m_ptr + k) % CH]) begin
                    g  = (m_ptr + k) % CH;
                    gv = 1;
                end
            end
        end
        ld = !m_valid || bus.out_ready;
        exp_ready = (!reset && ld && gv) ? (32'd1 << g) : 32'd0;
        chk("in_ready", 32'(bus.in_ready), exp_ready);
        @(posedge clk);
        if (reset) begin
            m_y = 0; m_ch = 0; m_valid = 0; m_ptr = 0;
        end else if (ld) begin
            if (gv) begin
                m_y     = int'((bus.d >> (g * WIDTH)) & 32'hFF);
                m_ch    = g;
                m_valid = 1;
                if (bus.mode) m_ptr = (g + 1) % CH;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        chk("y", 32'(bus.y), 32'(m_y));
        chk("y_valid", 32'(bus.y_valid), 32'(m_valid));
        chk("y_ch", 32'(bus.y_ch), 32'(m_ch));
    endtask

    task automatic drive(input logic md, input logic [SELW-1:0] s, input logic [CH-1:0] iv,
                         input logic ordy);
        bus.mode      = md;
        bus.sel       = s;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
    endtask

    initial begin
        logic [7:0] man_exp [4];
        int served [CH];
        man_exp = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

        // Reset with every channel valid, then idle release.
        reset = 1'b1;
        bus.d = 32'hD3C2B1A0;
        drive(1'b0, 2'd0, 4'b1111, 1'b1);
        cyc();
        cyc();
        chk("rst_y", 32'(bus.y), 32'h0);
        reset = 1'b0;
        drive(1'b0, 2'd0, 4'b0000, 1'b1);
        cyc();
        chk("idle_y_valid", 32'(bus.y_valid), 32'h0);

        // Manual select stepping through every channel.
        for (int i = 0; i < CH; i++) begin
            drive(1'b0, SELW'(i), 4'b1111, 1'b1);
            cyc();
            chk("man_y", 32'(bus.y), 32'(man_exp[i]));
            chk("man_ch", 32'(bus.y_ch), 32'(i));
        end

        // Round-robin with all channels valid, then only 1 and 3.
        drive(1'b1, 2'd0, 4'b1111, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("scan_ch", 32'(bus.y_ch), 32'(i % 4));
        end
        drive(1'b1, 2'd0, 4'b1010, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("scan_alt_ch", 32'(bus.y_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Back-pressure: load A0, stall three cycles, then drain to B1.
        drive(1'b1, 2'd0, 4'b1111, 1'b1);
        cyc();
        chk("bp_load", 32'(bus.y), 32'hA0);
        drive(1'b1, 2'd0, 4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_hold_y", 32'(bus.y), 32'hA0);
            chk("bp_hold_v", 32'(bus.y_valid), 32'h1);
        end
        drive(1'b1, 2'd0, 4'b1111, 1'b1);
        cyc();
        chk("bp_next", 32'(bus.y), 32'hB1);
        chk("bp_next_ch", 32'(bus.y_ch), 32'h1);

        // Invalid manual select, empty scan, then a lone channel 2.
        drive(1'b0, 2'd1, 4'b1101, 1'b1);
        cyc();
        chk("empty_man_v", 32'(bus.y_valid), 32'h0);
        chk("empty_man_y", 32'(bus.y), 32'hB1);
        drive(1'b1, 2'd0, 4'b0000, 1'b1);
        cyc();
        cyc();
        chk("empty_scan_v", 32'(bus.y_valid), 32'h0);
        drive(1'b1, 2'd0, 4'b0100, 1'b1);
        cyc();
        chk("lone_ch2", 32'(bus.y_ch), 32'h2);

        // Reset mid-operation: park ptr at 2 with a stalled word, then reset.
        drive(1'b1, 2'd0, 4'b0010, 1'b1);
        cyc();
        drive(1'b1, 2'd0, 4'b1111, 1'b0);
        cyc();
        reset = 1'b1;
        cyc();
        chk("midrst_v", 32'(bus.y_valid), 32'h0);
        reset = 1'b0;
        drive(1'b1, 2'd0, 4'b1111, 1'b1);
        cyc();
        chk("midrst_ch", 32'(bus.y_ch), 32'h0);

        // Fairness over 4 rounds of continuous scanning.
        for (int i = 0; i < CH; i++) served[i] = 0;
        for (int i = 0; i < 4 * CH; i++) begin
            bus.d = $urandom;
            cyc();
            served[bus.y_ch]++;
        end
        for (int i = 0; i < CH; i++)
            chk("fair", 32'(served[i]), 32'd4);

        // Random traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 31) == 0);
            bus.d = $urandom;
            drive(1'($urandom_range(0, 1)), SELW'($urandom_range(0, CH - 1)),
                  CH'($urandom), 1'($urandom_range(0, 3) != 0));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
